// File: rtl/audio_tone_gen.sv
// Square-wave note player with a one-deep note queue and tick-based duration.
// Latency: accepted load in IDLE starts the note next cycle; queued note follows the note end with no gap.
// Backpressure: ready drops while a note is held; a load is taken only when load and ready are both high.
module audio_tone_gen #(
  parameter int CNT_W = 17,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period_in,
  input  logic [DUR_W-1:0] dur_in,
  input  logic             load,
  output logic             ready,
  input  logic             tick,
  input  logic             stop,
  output logic             dout,
  output logic             busy,
  output logic             note_done
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [DUR_W-1:0] DUR_ONE = 1;

  state_t           state;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] cnt;
  logic [DUR_W-1:0] rem;
  logic [CNT_W-1:0] hold_period;
  logic [DUR_W-1:0] hold_dur;
  logic             hold_valid;
  logic             accept;
  logic             note_end;

  // A load transfers only while the hold slot is free.
  assign accept = load & ready;

  // A zero-length note ends at once; otherwise the tick that exhausts rem ends it.
  assign note_end = (state == PLAY) && ((rem == '0) || (tick && (rem == DUR_ONE)));

  assign busy = (state == PLAY);

  // Note sequencing, tone phase counter, duration countdown and hold slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dout        <= 1'b0;
      note_done   <= 1'b0;
      ready       <= 1'b1;
      hold_valid  <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      act_period  <= '0;
      hold_period <= '0;
      hold_dur    <= '0;
    end else if (stop) begin
      // Abort wins over load and tick; the queued note is dropped as well.
      state      <= IDLE;
      dout       <= 1'b0;
      cnt        <= '0;
      rem        <= '0;
      hold_valid <= 1'b0;
      ready      <= 1'b1;
      note_done  <= (state == PLAY);
    end else begin
      note_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= PLAY;
            act_period <= period_in;
            rem        <= dur_in;
            cnt        <= '0;
            dout       <= 1'b0;
          end
        end
        PLAY: begin
          if (note_end) begin
            note_done <= 1'b1;
            cnt       <= '0;
            dout      <= 1'b0;
            if (hold_valid) begin
              // Queued note takes over; phase restarts from zero.
              act_period <= hold_period;
              rem        <= hold_dur;
              hold_valid <= 1'b0;
              ready      <= 1'b1;
            end else if (accept) begin
              // Load arriving on the ending cycle chains straight on.
              act_period <= period_in;
              rem        <= dur_in;
            end else begin
              state <= IDLE;
            end
          end else begin
            // Equality compare keeps the counter from ever wrapping.
            if (cnt == act_period) begin
              cnt  <= '0;
              dout <= (act_period == '0) ? 1'b0 : ~dout;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
            if (tick) begin
              rem <= rem - DUR_ONE;
            end
            if (accept) begin
              hold_period <= period_in;
              hold_dur    <= dur_in;
              hold_valid  <= 1'b1;
              ready       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: per-cycle reference model, directed note table, corner sequences, random traffic.
// A second instance with CNT_W=4 checks the full-range half-period.
// All checks are sampled 1 time unit after the rising edge.
module tb_audio_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] period_in;
  logic [15:0] dur_in;
  logic        load, tick, stop;
  logic        ready, dout, busy, note_done;

  logic [3:0]  period2;
  logic [15:0] dur2;
  logic        load2, tick2, stop2;
  logic        ready2, dout2, busy2, done2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  audio_tone_gen dut (
    .clk(clk), .rst_n(rst_n), .period_in(period_in), .dur_in(dur_in), .load(load),
    .ready(ready), .tick(tick), .stop(stop), .dout(dout), .busy(busy), .note_done(note_done)
  );

  audio_tone_gen #(.CNT_W(4), .DUR_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .period_in(period2), .dur_in(dur2), .load(load2),
    .ready(ready2), .tick(tick2), .stop(stop2), .dout(dout2), .busy(busy2), .note_done(done2)
  );

  // Reference model: a note is (period, duration); its waveform is a function of the
  // number of cycles since it started, and it ends when enough ticks have been seen.
  bit     m_play, m_done, m_hv;
  longint m_per, m_dur, m_age, m_ticks, m_hp, m_hd;

  function automatic void m_start(longint p, longint d);
    m_play  = 1'b1;
    m_per   = p;
    m_dur   = d;
    m_age   = 0;
    m_ticks = 0;
  endfunction

  function automatic void m_step(bit r, bit s, bit l, bit t, longint p, longint d);
    bit acc, ending;
    acc = l && !m_hv;
    if (!r) begin
      m_play = 1'b0; m_hv = 1'b0; m_done = 1'b0;
    end else if (s) begin
      m_done = m_play; m_play = 1'b0; m_hv = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_play) begin
        if (acc) m_start(p, d);
      end else begin
        ending = (m_dur == 0) || (t && (m_ticks + 1 >= m_dur));
        if (ending) begin
          m_done = 1'b1;
          if (m_hv) begin
            m_start(m_hp, m_hd);
            m_hv = 1'b0;
          end else if (acc) begin
            m_start(p, d);
          end else begin
            m_play = 1'b0;
          end
        end else begin
          m_age++;
          if (t) m_ticks++;
          if (acc) begin
            m_hv = 1'b1; m_hp = p; m_hd = d;
          end
        end
      end
    end
  endfunction

  function automatic bit m_dout();
    if (!m_play || m_per == 0) return 1'b0;
    return ((m_age / (m_per + 1)) % 2) == 1;
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare all outputs.
  task automatic step(bit r, bit s, bit l, bit t, int p, int d);
    rst_n = r; stop = s; load = l; tick = t;
    period_in = 17'(p); dur_in = 16'(d);
    @(posedge clk);
    #1;
    cyc++;
    m_step(r, s, l, t, longint'(p), longint'(d));
    check("dout", dout, m_dout());
    check("busy", busy, m_play);
    check("ready", ready, !m_hv);
    check("note_done", note_done, m_done);
  endtask

  typedef struct {
    int p;        // period_in
    int d;        // dur_in
    int t;        // tick interval in clocks
    int busy_len; // samples with busy high
    int toggles;  // dout edges while busy
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, blen, tog, bad, dones, last, gap;
    bit prev;

    vecs[0] = '{p: 3, d: 2, t: 100, busy_len: 200, toggles: 49};
    vecs[1] = '{p: 0, d: 4, t: 10,  busy_len: 40,  toggles: 0};
    vecs[2] = '{p: 0, d: 0, t: 10,  busy_len: 1,   toggles: 0};
    vecs[3] = '{p: 1, d: 3, t: 5,   busy_len: 15,  toggles: 7};
    vecs[4] = '{p: 5, d: 1, t: 7,   busy_len: 7,   toggles: 1};
    vecs[5] = '{p: 2, d: 1, t: 1,   busy_len: 1,   toggles: 0};
    vecs[6] = '{p: 7, d: 3, t: 20,  busy_len: 60,  toggles: 7};

    period2 = '0; dur2 = '0; load2 = 1'b0; tick2 = 1'b0; stop2 = 1'b0;
    m_play = 0; m_done = 0; m_hv = 0;
    m_per = 0; m_dur = 0; m_age = 0; m_ticks = 0; m_hp = 0; m_hd = 0;

    // Reset state, with load/tick/stop active to show reset wins.
    step(0, 1, 1, 1, 5, 5);
    step(0, 0, 1, 1, 5, 5);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_done", note_done, 0);
    step(1, 0, 0, 0, 0, 0);

    // Full-range half-period on the 4-bit instance: 10 periods of 16+16 clocks.
    period2 = 4'd15; dur2 = 16'd1; load2 = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    load2 = 1'b0;
    check("w4_busy", busy2, 1);
    check("w4_start_dout", dout2, 0);
    tog = 0; bad = 0; last = 0; prev = dout2;
    for (int k = 1; k <= 320; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (dout2 != prev) begin
        tog++;
        if (k - last != 16) bad++;
        last = k;
      end
      prev = dout2;
    end
    check("w4_toggles", tog, 20);
    check("w4_bad_intervals", bad, 0);
    check("w4_still_busy", busy2, 1);
    tick2 = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    tick2 = 1'b0;
    check("w4_done", done2, 1);
    check("w4_idle", busy2, 0);
    check("w4_dout_low", dout2, 0);

    // Directed note table; period_in/dur_in wander while no load is presented.
    foreach (vecs[i]) begin
      step(1, 0, 1, 0, vecs[i].p, vecs[i].d);
      blen = 0; tog = 0; bad = 0; dones = 0; last = 0; c = 0;
      prev = dout;
      while (busy && c < 2000) begin
        blen++;
        c++;
        step(1, 0, 0, (c % vecs[i].t) == 0, $urandom_range(0, 31), $urandom_range(0, 9));
        if (busy && dout != prev) begin
          tog++;
          if (c - last != vecs[i].p + 1) bad++;
          last = c;
        end
        prev = dout;
        if (note_done) dones++;
      end
      check($sformatf("vec%0d_busy_len", i), blen, vecs[i].busy_len);
      check($sformatf("vec%0d_toggles", i), tog, vecs[i].toggles);
      check($sformatf("vec%0d_intervals", i), bad, 0);
      check($sformatf("vec%0d_done_count", i), dones, 1);
      check($sformatf("vec%0d_dout_end", i), dout, 0);
      step(1, 0, 0, 0, 0, 0);
    end

    // Queued note B behind A: no busy gap, B restarts phase and toggles every 6 clocks.
    step(1, 0, 1, 0, 1, 3);
    gap = 0;
    for (int k = 1; k <= 15; k++) begin
      step(1, 0, k == 1, (k % 5) == 0, 5, 1);
      if (k == 1) check("q_ready_low", ready, 0);
      if (!busy) gap++;
    end
    check("q_busy_gap", gap, 0);
    check("q_a_done", note_done, 1);
    check("q_b_dout0", dout, 0);
    check("q_ready_back", ready, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (k == 5) check("q_b_before_toggle", dout, 0);
      if (k == 6) check("q_b_toggle", dout, 1);
    end
    step(1, 0, 0, 1, 0, 0);
    check("q_b_end", busy, 0);
    step(1, 0, 0, 0, 0, 0);

    // Stop with a held note and simultaneous load+tick.
    step(1, 0, 1, 0, 2, 5);
    step(1, 0, 1, 0, 3, 5);
    step(1, 0, 0, 0, 0, 0);
    check("s_held", ready, 0);
    step(1, 1, 1, 1, 4, 4);
    check("s_idle", busy, 0);
    check("s_ready", ready, 1);
    check("s_done", note_done, 1);
    check("s_dout", dout, 0);
    step(1, 0, 0, 0, 0, 0);
    check("s_load_ignored", busy, 0);
    step(1, 1, 0, 0, 0, 0);
    check("s_idle_no_done", note_done, 0);

    // Reset mid-note with a held note, then a normal note.
    step(1, 0, 1, 0, 2, 5);
    step(1, 0, 1, 0, 3, 5);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1, 1);
    check("r_busy", busy, 0);
    check("r_ready", ready, 1);
    check("r_done", note_done, 0);
    check("r_dout", dout, 0);
    step(1, 0, 1, 0, 1, 1);
    check("r_restart", busy, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("r_toggle", dout, 1);
    step(1, 0, 0, 1, 0, 0);
    check("r_end_done", note_done, 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7),
           $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_tone_gen.md
AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 Parameter CNT_W, default 17, width of half-period count and period input.
REQ-002 Parameter DUR_W, default 16, width of note-duration count in tick units.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 period_in  input  CNT_W  half-period minus one, in clk cycles; 0 = rest (silent note).
REQ-006 dur_in  input  DUR_W  note length in tick strobes.
REQ-007 load  input  1  note-request valid; transfer when load=1 and ready=1 on the same edge.
REQ-008 ready  output  1  note slot free; equals NOT hold_valid, registered.
REQ-009 tick  input  1  duration time-base strobe, one clk wide (e.g. 1 ms).
REQ-010 stop  input  1  abort current note and flush the queued note.
REQ-011 dout  output  1  square-wave audio output, registered.
REQ-012 busy  output  1  high while a note is playing (state PLAY).
REQ-013 note_done  output  1  one-cycle pulse at each note end (natural or by stop).

Function
REQ-014 Internal state: two-state FSM IDLE/PLAY; active note registers (period, remaining duration, cnt); one-deep hold register (period, dur, hold_valid).
REQ-015 IDLE: dout=0, busy=0, cnt=0; accepted load starts the note: PLAY on next cycle with cnt=0, dout=0, rem=dur_in.
REQ-016 PLAY: accepted load is written to the hold register; hold_valid=1, ready=0 from next cycle.
REQ-017 Tone: each PLAY cycle, if cnt==period then cnt<=0 and dout toggles, else cnt<=cnt+1; half-period = period+1 clocks, full period = 2*(period+1).
REQ-018 Rest: period=0 in the active note forces dout=0, no toggles; duration counts normally.
REQ-019 Counter never wraps: cnt compared with equality against the latched period; period=2^CNT_W-1 gives half-period 2^CNT_W clocks.
REQ-020 Duration: on each tick in PLAY, if rem<=1 the note ends that cycle, else rem<=rem-1; ticks in IDLE ignored.
REQ-021 dur_in=0: note ends in its first PLAY cycle irrespective of tick; dout stays 0.
REQ-022 Note end: note_done=1 for the following cycle; if hold_valid, the held note becomes active next cycle (busy stays 1, cnt=0, dout=0, hold_valid=0), else return to IDLE with dout=0.
REQ-023 Load accepted in the same cycle a note ends with hold empty: new note starts next cycle with no IDLE gap; exactly one note_done pulse.
REQ-024 Phase is reset at every note start: dout=0, cnt=0; no carry-over of phase from previous note.
REQ-025 stop=1: next cycle state IDLE, dout=0, cnt=0, hold_valid=0, ready=1; note_done pulses only if state was PLAY.
REQ-026 stop has priority over load and tick in the same cycle; a load in that cycle is discarded.
REQ-027 period_in and dur_in sampled only on accepted load; changes at other times have no effect.

Reset
REQ-028 rst_n=0 on a rising edge: state IDLE, dout=0, busy=0, note_done=0, ready=1, hold_valid=0, cnt=0, rem=0.
REQ-029 Reset mid-note or with a queued note discards both; no note_done pulse generated by reset.
REQ-030 Reset has priority over stop, load and tick.

Verification
REQ-031 period_in=3, dur_in=2, load in IDLE, tick every 100 clks -> dout toggles every 4 clks (period 8); note ends at 2nd tick; one note_done; busy falls; dout=0.
REQ-032 Note A (period 1, dur 3) playing, load note B (period 5, dur 1) -> ready=0 until A ends; B starts next cycle, no busy gap, dout restarts from 0, toggles every 6 clks.
REQ-033 period_in=0, dur_in=4 -> dout constant 0 for 4 ticks, then note_done; dur_in=0 -> note_done pulse one cycle after PLAY entry, no toggles.
REQ-034 stop asserted mid-note with a held note, plus load and tick same cycle -> IDLE next cycle, hold flushed, ready=1, one note_done, load ignored.
REQ-035 rst_n=0 mid-note with hold_valid=1 -> all outputs to reset values next edge, no note_done; next load plays normally.
REQ-036 CNT_W=4, period_in=15 -> half-period exactly 16 clks, no counter wrap or glitch over 10 periods.
